// File: rtl/rsa_pkg.sv
// Shared widths, source identifiers and FSM encoding for the FastModExp arbiter.
package rsa_pkg;

  localparam int   WORD_W  = 32;
  localparam logic SRC_DEC = 1'b0;
  localparam logic SRC_ENC = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LAUNCH  = 2'd1,
    ST_WAIT    = 2'd2,
    ST_DELIVER = 2'd3
  } arb_state_e;

endpackage

// File: rtl/fme_pending_slot.sv
// One-deep pending slot: holds a single offered word until the arbiter grants it.
module fme_pending_slot
  import rsa_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic [WORD_W-1:0] i_word,
  input  logic              i_grant,
  output logic              o_valid,
  output logic [WORD_W-1:0] o_word,
  output logic              o_drop
);

  logic              r_valid;
  logic [WORD_W-1:0] r_word;

  // A start is only refused when the slot is full and not draining this cycle.
  assign o_drop  = i_start & r_valid & ~i_grant;
  assign o_valid = r_valid;
  assign o_word  = r_word;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_word  <= '0;
    end else if (o_drop) begin
      r_valid <= r_valid;
    end else if (i_start) begin
      r_valid <= 1'b1;
      r_word  <= i_word;
    end else if (i_grant) begin
      r_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fme_arbiter.sv
// Shares one FastModExp core between a decrypt and an encrypt source with
// round-robin grant, launch/wait/deliver sequencing and a job timeout.
module fme_arbiter
  import rsa_pkg::*;
#(
  parameter int TIMEOUT = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dec_start,
  input  logic [WORD_W-1:0] dec_word,
  input  logic              enc_start,
  input  logic [WORD_W-1:0] enc_word,
  output logic              fme_start,
  output logic [WORD_W-1:0] fme_data_in,
  output logic              fme_key_sel,
  input  logic              fme_done,
  input  logic [WORD_W-1:0] fme_data_out,
  output logic              res_valid,
  output logic [WORD_W-1:0] res_data,
  output logic              res_src,
  input  logic              res_ready,
  output logic              busy,
  output logic              overrun,
  output logic              timeout_err
);

  localparam int TMR_W = ($clog2(TIMEOUT + 1) > 13) ? $clog2(TIMEOUT + 1) : 13;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
  localparam logic [TMR_W-1:0] TMR_MAX  = {TMR_W{1'b1}};

  arb_state_e        r_state, w_next;
  logic [TMR_W-1:0]  r_timer;
  logic              r_last_grant;
  logic              r_fme_start, r_key_sel, r_res_valid, r_res_src;
  logic              r_overrun, r_timeout_err;
  logic [WORD_W-1:0] r_fme_data_in, r_res_data;
  logic              w_grant_dec, w_grant_enc, w_timeout;
  logic              w_dec_valid, w_enc_valid, w_dec_drop, w_enc_drop;
  logic [WORD_W-1:0] w_dec_word, w_enc_word;

  fme_pending_slot u_dec_slot (
    .clk(clk), .rst(rst), .i_start(dec_start), .i_word(dec_word),
    .i_grant(w_grant_dec), .o_valid(w_dec_valid), .o_word(w_dec_word), .o_drop(w_dec_drop)
  );

  fme_pending_slot u_enc_slot (
    .clk(clk), .rst(rst), .i_start(enc_start), .i_word(enc_word),
    .i_grant(w_grant_enc), .o_valid(w_enc_valid), .o_word(w_enc_word), .o_drop(w_enc_drop)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // On a tie the source that did not win last time is granted.
  always_comb begin
    w_next      = r_state;
    w_grant_dec = 1'b0;
    w_grant_enc = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_dec_valid && w_enc_valid) begin
          w_grant_dec = (r_last_grant == SRC_ENC);
          w_grant_enc = (r_last_grant == SRC_DEC);
          w_next      = ST_LAUNCH;
        end else if (w_dec_valid) begin
          w_grant_dec = 1'b1;
          w_next      = ST_LAUNCH;
        end else if (w_enc_valid) begin
          w_grant_enc = 1'b1;
          w_next      = ST_LAUNCH;
        end else begin
          w_next = ST_IDLE;
        end
      end
      ST_LAUNCH: w_next = ST_WAIT;
      ST_WAIT: begin
        if (fme_done) begin
          w_next = ST_DELIVER;
        end else if (r_timer == TMR_LAST) begin
          w_timeout = 1'b1;
          w_next    = ST_IDLE;
        end else begin
          w_next = ST_WAIT;
        end
      end
      ST_DELIVER: begin
        if (res_ready) w_next = ST_IDLE;
        else           w_next = ST_DELIVER;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Datapath, timer and sticky flags; the core operand and key hold from grant until the job ends.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fme_start   <= 1'b0;
      r_fme_data_in <= '0;
      r_key_sel     <= 1'b0;
      r_timer       <= '0;
      r_res_valid   <= 1'b0;
      r_res_data    <= '0;
      r_res_src     <= 1'b0;
      r_overrun     <= 1'b0;
      r_timeout_err <= 1'b0;
      r_last_grant  <= SRC_ENC;
    end else begin
      r_fme_start <= w_grant_dec | w_grant_enc;
      if (w_grant_dec) begin
        r_fme_data_in <= w_dec_word;
        r_key_sel     <= SRC_DEC;
      end else if (w_grant_enc) begin
        r_fme_data_in <= w_enc_word;
        r_key_sel     <= SRC_ENC;
      end
      if (r_state == ST_LAUNCH)                        r_timer <= '0;
      else if (r_state == ST_WAIT && r_timer != TMR_MAX) r_timer <= r_timer + TMR_W'(1);
      if (r_state == ST_WAIT && fme_done) begin
        r_res_valid <= 1'b1;
        r_res_data  <= fme_data_out;
        r_res_src   <= r_key_sel;
      end
      if (r_state == ST_DELIVER && res_ready) begin
        r_res_valid  <= 1'b0;
        r_last_grant <= r_res_src;
      end
      if (w_timeout) begin
        r_timeout_err <= 1'b1;
        r_last_grant  <= r_key_sel;
      end
      if (w_dec_drop || w_enc_drop) r_overrun <= 1'b1;
    end
  end

  assign fme_start   = r_fme_start;
  assign fme_data_in = r_fme_data_in;
  assign fme_key_sel = r_key_sel;
  assign res_valid   = r_res_valid;
  assign res_data    = r_res_data;
  assign res_src     = r_res_src;
  assign overrun     = r_overrun;
  assign timeout_err = r_timeout_err;
  assign busy        = (r_state != ST_IDLE) | w_dec_valid | w_enc_valid;

endmodule

// File: tb/tb_fme_arbiter.sv
// Directed self-checking bench for fme_arbiter, built with a 16-cycle timeout.
module tb_fme_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        dec_start, enc_start, fme_done, res_ready;
  logic [31:0] dec_word, enc_word, fme_data_out;
  logic        fme_start, fme_key_sel, res_valid, res_src, busy, overrun, timeout_err;
  logic [31:0] fme_data_in, res_data;
  int          n_pass = 0;
  int          n_total = 0;

  fme_arbiter #(.TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .dec_start(dec_start), .dec_word(dec_word),
    .enc_start(enc_start), .enc_word(enc_word),
    .fme_start(fme_start), .fme_data_in(fme_data_in), .fme_key_sel(fme_key_sel),
    .fme_done(fme_done), .fme_data_out(fme_data_out),
    .res_valid(res_valid), .res_data(res_data), .res_src(res_src), .res_ready(res_ready),
    .busy(busy), .overrun(overrun), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; dec_start = 1'b0; enc_start = 1'b0; fme_done = 1'b0; res_ready = 1'b0;
    dec_word = 32'h0; enc_word = 32'h0; fme_data_out = 32'h0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_total++;
    if ({fme_start, fme_key_sel, res_valid, res_src, busy, overrun, timeout_err} !== 7'b0) begin
      $display("FAIL reset_flags: got %b want 0000000",
               {fme_start, fme_key_sel, res_valid, res_src, busy, overrun, timeout_err});
    end else n_pass++;
    n_total++;
    if ({fme_data_in, res_data} !== 64'h0) $display("FAIL reset_data: got %h/%h want 0/0", fme_data_in, res_data);
    else n_pass++;
  endtask

  task automatic test_single_decrypt();
    do_reset();
    dec_start = 1'b1; dec_word = 32'h0000_1234;
    tick();
    dec_start = 1'b0; dec_word = 32'h0;
    n_total++;
    if (fme_start !== 1'b0) $display("FAIL dec_early_start: got %b want 0", fme_start); else n_pass++;
    tick();
    n_total++;
    if ({fme_start, fme_key_sel, fme_data_in} !== {1'b1, 1'b0, 32'h0000_1234})
      $display("FAIL dec_launch: got %b %b %h want 1 0 00001234", fme_start, fme_key_sel, fme_data_in);
    else n_pass++;
    tick();
    n_total++;
    if ({fme_start, res_valid} !== 2'b00) $display("FAIL dec_wait: got %b want 00", {fme_start, res_valid}); else n_pass++;
    fme_done = 1'b1; fme_data_out = 32'h0000_ABCD;
    tick();
    fme_done = 1'b0; fme_data_out = 32'h0;
    n_total++;
    if ({res_valid, res_src, res_data} !== {1'b1, 1'b0, 32'h0000_ABCD})
      $display("FAIL dec_result: got %b %b %h want 1 0 0000abcd", res_valid, res_src, res_data);
    else n_pass++;
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    n_total++;
    if ({res_valid, busy} !== 2'b00) $display("FAIL dec_accept: got %b want 00", {res_valid, busy}); else n_pass++;
  endtask

  task automatic test_tie();
    do_reset();
    dec_start = 1'b1; dec_word = 32'h1111_0000; enc_start = 1'b1; enc_word = 32'h2222_0000;
    tick();
    dec_start = 1'b0; enc_start = 1'b0;
    tick();
    n_total++;
    if ({fme_start, fme_key_sel, fme_data_in} !== {1'b1, 1'b0, 32'h1111_0000})
      $display("FAIL tie_first: got %b %b %h want 1 0 11110000", fme_start, fme_key_sel, fme_data_in);
    else n_pass++;
    tick();
    fme_done = 1'b1; fme_data_out = 32'h0000_0D0D;
    tick();
    fme_done = 1'b0;
    n_total++;
    if ({res_valid, res_src, res_data, busy} !== {1'b1, 1'b0, 32'h0000_0D0D, 1'b1})
      $display("FAIL tie_dec_result: got %b %b %h %b want 1 0 00000d0d 1", res_valid, res_src, res_data, busy);
    else n_pass++;
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    n_total++;
    if (fme_start !== 1'b0) $display("FAIL tie_gap: got %b want 0", fme_start); else n_pass++;
    tick();
    n_total++;
    if ({fme_start, fme_key_sel, fme_data_in} !== {1'b1, 1'b1, 32'h2222_0000})
      $display("FAIL tie_second: got %b %b %h want 1 1 22220000", fme_start, fme_key_sel, fme_data_in);
    else n_pass++;
    tick();
    fme_done = 1'b1; fme_data_out = 32'h0000_0E0E;
    tick();
    fme_done = 1'b0;
    n_total++;
    if ({res_valid, res_src, res_data} !== {1'b1, 1'b1, 32'h0000_0E0E})
      $display("FAIL tie_enc_result: got %b %b %h want 1 1 00000e0e", res_valid, res_src, res_data);
    else n_pass++;
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  task automatic test_overrun();
    do_reset();
    dec_start = 1'b1; dec_word = 32'h0000_00A1;
    tick();
    dec_word = 32'h0000_00B2;          // granted this cycle: refills the slot
    tick();
    n_total++;
    if ({overrun, fme_start, fme_data_in} !== {1'b0, 1'b1, 32'h0000_00A1})
      $display("FAIL ovr_refill: got %b %b %h want 0 1 000000a1", overrun, fme_start, fme_data_in);
    else n_pass++;
    dec_word = 32'h0000_00C3;          // slot full, not granted: dropped
    tick();
    dec_start = 1'b0;
    n_total++;
    if ({overrun, fme_data_in} !== {1'b1, 32'h0000_00A1})
      $display("FAIL ovr_drop: got %b %h want 1 000000a1", overrun, fme_data_in);
    else n_pass++;
    fme_done = 1'b1; fme_data_out = 32'h0000_0001;
    tick();
    fme_done = 1'b0; res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    tick();
    n_total++;
    if ({fme_start, fme_data_in, overrun} !== {1'b1, 32'h0000_00B2, 1'b1})
      $display("FAIL ovr_next: got %b %h %b want 1 000000b2 1", fme_start, fme_data_in, overrun);
    else n_pass++;
  endtask

  task automatic test_timeout();
    logic seen_valid;
    do_reset();
    enc_start = 1'b1; enc_word = 32'h0000_7777;
    tick();
    enc_start = 1'b0;
    tick();                            // LAUNCH
    tick();                            // WAIT cycle 1
    seen_valid = 1'b0;
    for (int i = 2; i <= 16; i++) begin
      seen_valid = seen_valid | res_valid;
      tick();
    end
    n_total++;
    if ({timeout_err, busy, seen_valid} !== 3'b010)
      $display("FAIL to_wait16: got %b want 010", {timeout_err, busy, seen_valid});
    else n_pass++;
    tick();
    n_total++;
    if ({timeout_err, busy, res_valid} !== 3'b100)
      $display("FAIL to_abort: got %b want 100", {timeout_err, busy, res_valid});
    else n_pass++;
    fme_done = 1'b1; fme_data_out = 32'hDEAD_BEEF;
    tick();
    fme_done = 1'b0;
    n_total++;
    if ({res_valid, res_data, busy} !== {1'b0, 32'h0, 1'b0})
      $display("FAIL to_late_done: got %b %h %b want 0 00000000 0", res_valid, res_data, busy);
    else n_pass++;
  endtask

  task automatic test_hold();
    do_reset();
    dec_start = 1'b1; dec_word = 32'h0000_0042;
    tick();
    dec_start = 1'b0;
    tick(); tick();
    enc_start = 1'b1; enc_word = 32'h0000_0099;
    fme_done = 1'b1; fme_data_out = 32'h0000_5A5A;
    tick();
    enc_start = 1'b0; fme_done = 1'b0; fme_data_out = 32'h0;
    for (int i = 0; i < 10; i++) begin
      n_total++;
      if ({res_valid, res_src, fme_start, res_data} !== {1'b1, 1'b0, 1'b0, 32'h0000_5A5A})
        $display("FAIL hold_%0d: got %b %b %b %h want 1 0 0 00005a5a", i, res_valid, res_src, fme_start, res_data);
      else n_pass++;
      tick();
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    tick();
    n_total++;
    if ({fme_start, fme_key_sel, fme_data_in} !== {1'b1, 1'b1, 32'h0000_0099})
      $display("FAIL hold_release: got %b %b %h want 1 1 00000099", fme_start, fme_key_sel, fme_data_in);
    else n_pass++;
  endtask

  task automatic test_reset_mid_job();
    do_reset();
    dec_start = 1'b1; dec_word = 32'h0000_3333;
    tick();
    dec_start = 1'b0;
    tick(); tick();                    // now in WAIT
    rst = 1'b1;
    tick();
    rst = 1'b0;
    fme_done = 1'b1; fme_data_out = 32'h0000_4444;
    tick();
    fme_done = 1'b0;
    n_total++;
    if ({fme_start, fme_key_sel, res_valid, res_src, busy, overrun, timeout_err, fme_data_in, res_data} !== 71'h0)
      $display("FAIL rst_mid_job: got %b %b %b %b %b %b %b %h %h want all 0",
               fme_start, fme_key_sel, res_valid, res_src, busy, overrun, timeout_err, fme_data_in, res_data);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single_decrypt();
    test_tie();
    test_overrun();
    test_timeout();
    test_hold();
    test_reset_mid_job();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
